// File: rtl/mult_chk_pkg.sv
// Shared types and default sizing for the multiplier result checker.
package mult_chk_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_chk_shift_add.sv
// Golden sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// prod is a lookahead of the accumulator, so it already holds the final product while done is high.
module mult_chk_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [PW-1:0]    w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_b_sh[0] ? r_a_sh : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH);
      r_acc  <= '0;
      r_a_sh <= {{WIDTH{1'b0}}, a};
      r_b_sh <= b;
    end else if (r_busy) begin
      r_acc  <= w_acc_nxt;
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CW'(1));
  assign prod = w_acc_nxt;

endmodule

// File: rtl/mult_result_checker.sv
// Self-checking sink: compares a candidate product against a shift-add golden product
// and keeps saturating match/error statistics plus a first-failure snapshot.
module mult_result_checker
  import mult_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2*WIDTH-1:0]       in_p,
  output logic                     res_valid,
  output logic                     res_match,
  output logic [2*WIDTH-1:0]       res_err,
  output logic [CNT_W-1:0]         vec_count,
  output logic [CNT_W-1:0]         mismatch_count,
  output logic [2*WIDTH+CNT_W-1:0] err_sum,
  output logic [2*WIDTH-1:0]       max_err,
  output logic                     fail_valid,
  output logic [WIDTH-1:0]         fail_a,
  output logic [WIDTH-1:0]         fail_b,
  output logic [2*WIDTH-1:0]       fail_p
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + CNT_W;

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_busy, w_done;
  logic [PW-1:0]    w_prod, w_diff;
  logic [WIDTH-1:0] r_a, r_b;
  logic [PW-1:0]    r_p;

  logic             r_in_ready, r_res_valid, r_res_match, r_fail_valid;
  logic [PW-1:0]    r_res_err, r_max_err, r_fail_p;
  logic [CNT_W-1:0] r_vec_count, r_mismatch_count;
  logic [SW-1:0]    r_err_sum;
  logic [WIDTH-1:0] r_fail_a, r_fail_b;

  logic [CNT_W-1:0] w_vec_inc, w_mis_inc;
  logic [SW:0]      w_sum_ext;
  logic [SW-1:0]    w_sum_sat;

  assign w_accept = (r_state == IDLE) && !w_busy && in_valid && !clear;

  mult_chk_shift_add #(.WIDTH(WIDTH)) u_golden (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_accept),
    .abort (clear),
    .a     (in_a),
    .b     (in_b),
    .busy  (w_busy),
    .done  (w_done),
    .prod  (w_prod)
  );

  // Absolute difference of two unsigned PW-bit values always fits in PW bits.
  assign w_diff = (r_p >= w_prod) ? (r_p - w_prod) : (w_prod - r_p);

  assign w_vec_inc = (r_vec_count == '1) ? r_vec_count : r_vec_count + CNT_W'(1);
  assign w_mis_inc = (r_mismatch_count == '1) ? r_mismatch_count : r_mismatch_count + CNT_W'(1);
  assign w_sum_ext = {1'b0, r_err_sum} + (SW + 1)'(r_res_err);
  assign w_sum_sat = w_sum_ext[SW] ? '1 : w_sum_ext[SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = MUL;
        MUL:     if (w_done)   w_state_nxt = CMP;
        CMP:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready       <= 1'b1;
      r_res_valid      <= 1'b0;
      r_res_match      <= 1'b0;
      r_res_err        <= '0;
      r_vec_count      <= '0;
      r_mismatch_count <= '0;
      r_err_sum        <= '0;
      r_max_err        <= '0;
      r_fail_valid     <= 1'b0;
      r_fail_a         <= '0;
      r_fail_b         <= '0;
      r_fail_p         <= '0;
      r_a              <= '0;
      r_b              <= '0;
      r_p              <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_res_valid <= 1'b0;
      if (clear) begin
        r_vec_count      <= '0;
        r_mismatch_count <= '0;
        r_err_sum        <= '0;
        r_max_err        <= '0;
        r_fail_valid     <= 1'b0;
        r_fail_a         <= '0;
        r_fail_b         <= '0;
        r_fail_p         <= '0;
      end else begin
        if (w_accept) begin
          r_a <= in_a;
          r_b <= in_b;
          r_p <= in_p;
        end
        // Result is registered on the edge entering CMP so it is visible with res_valid.
        if ((r_state == MUL) && w_done) begin
          r_res_valid <= 1'b1;
          r_res_match <= (w_diff == '0);
          r_res_err   <= w_diff;
        end
        if (r_state == CMP) begin
          r_vec_count <= w_vec_inc;
          r_err_sum   <= w_sum_sat;
          if (r_res_err > r_max_err) begin
            r_max_err <= r_res_err;
          end
          if (r_res_err != '0) begin
            r_mismatch_count <= w_mis_inc;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_a     <= r_a;
              r_fail_b     <= r_b;
              r_fail_p     <= r_p;
            end
          end
        end
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign res_valid      = r_res_valid;
  assign res_match      = r_res_match;
  assign res_err        = r_res_err;
  assign vec_count      = r_vec_count;
  assign mismatch_count = r_mismatch_count;
  assign err_sum        = r_err_sum;
  assign max_err        = r_max_err;
  assign fail_valid     = r_fail_valid;
  assign fail_a         = r_fail_a;
  assign fail_b         = r_fail_b;
  assign fail_p         = r_fail_p;

endmodule

// File: tb/tb_mult_result_checker.sv
// Bench for mult_result_checker: default, narrow-counter and WIDTH=2 instances against an arithmetic model.
module tb_mult_result_checker;

  logic clk = 1'b0;
  logic rst_n, clear;
  logic iv_m, iv_c, iv_2;
  logic [7:0]  va, vb;
  logic [15:0] vp;
  logic [1:0]  wa, wb;
  logic [3:0]  wp;

  logic rdy_m, rv_m, rm_m, fv_m;
  logic [15:0] re_m, vc_m, mc_m, mx_m, fp_m;
  logic [31:0] es_m;
  logic [7:0]  fa_m, fb_m;

  logic rdy_c, rv_c, rm_c, fv_c;
  logic [15:0] re_c, mx_c, fp_c;
  logic [1:0]  vc_c, mc_c;
  logic [17:0] es_c;
  logic [7:0]  fa_c, fb_c;

  logic rdy_2, rv_2, rm_2, fv_2;
  logic [3:0]  re_2, mx_2, fp_2;
  logic [15:0] vc_2, mc_2;
  logic [19:0] es_2;
  logic [1:0]  fa_2, fb_2;

  int total = 0;
  int bad = 0;

  longint m_vec[2], m_mis[2], m_sum[2], m_max[2], m_fv[2], m_fa[2], m_fb[2], m_fp[2];
  longint cmax[2], smax[2];
  longint m2_vec;

  always #5 clk = ~clk;

  mult_result_checker #(.WIDTH(8), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv_m), .in_ready(rdy_m),
    .in_a(va), .in_b(vb), .in_p(vp), .res_valid(rv_m), .res_match(rm_m), .res_err(re_m),
    .vec_count(vc_m), .mismatch_count(mc_m), .err_sum(es_m), .max_err(mx_m),
    .fail_valid(fv_m), .fail_a(fa_m), .fail_b(fb_m), .fail_p(fp_m)
  );

  mult_result_checker #(.WIDTH(8), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv_c), .in_ready(rdy_c),
    .in_a(va), .in_b(vb), .in_p(vp), .res_valid(rv_c), .res_match(rm_c), .res_err(re_c),
    .vec_count(vc_c), .mismatch_count(mc_c), .err_sum(es_c), .max_err(mx_c),
    .fail_valid(fv_c), .fail_a(fa_c), .fail_b(fb_c), .fail_p(fp_c)
  );

  mult_result_checker #(.WIDTH(2), .CNT_W(16)) u_w2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv_2), .in_ready(rdy_2),
    .in_a(wa), .in_b(wb), .in_p(wp), .res_valid(rv_2), .res_match(rm_2), .res_err(re_2),
    .vec_count(vc_2), .mismatch_count(mc_2), .err_sum(es_2), .max_err(mx_2),
    .fail_valid(fv_2), .fail_a(fa_2), .fail_b(fb_2), .fail_p(fp_2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_vec[s] = 0; m_mis[s] = 0; m_sum[s] = 0; m_max[s] = 0;
      m_fv[s] = 0;  m_fa[s] = 0;  m_fb[s] = 0;  m_fp[s] = 0;
    end
    m2_vec = 0;
  endtask

  // Arithmetic reference: golden = a*b, error = |p - golden|, saturating statistics.
  task automatic model_update(input int sel, input longint a, input longint b, input longint p);
    longint g, e;
    g = a * b;
    e = (p >= g) ? p - g : g - p;
    m_vec[sel] = (m_vec[sel] + 1 > cmax[sel]) ? cmax[sel] : m_vec[sel] + 1;
    m_sum[sel] = (m_sum[sel] + e > smax[sel]) ? smax[sel] : m_sum[sel] + e;
    if (e > m_max[sel]) m_max[sel] = e;
    if (e != 0) begin
      m_mis[sel] = (m_mis[sel] + 1 > cmax[sel]) ? cmax[sel] : m_mis[sel] + 1;
      if (m_fv[sel] == 0) begin
        m_fv[sel] = 1; m_fa[sel] = a; m_fb[sel] = b; m_fp[sel] = p;
      end
    end
  endtask

  task automatic check_stats(input int sel);
    if (sel == 0) begin
      chk("vec_count", vc_m, m_vec[0]);
      chk("mismatch_count", mc_m, m_mis[0]);
      chk("err_sum", es_m, m_sum[0]);
      chk("max_err", mx_m, m_max[0]);
      chk("fail_valid", fv_m, m_fv[0]);
      chk("fail_a", fa_m, m_fa[0]);
      chk("fail_b", fb_m, m_fb[0]);
      chk("fail_p", fp_m, m_fp[0]);
    end else begin
      chk("c2_vec_count", vc_c, m_vec[1]);
      chk("c2_mismatch_count", mc_c, m_mis[1]);
      chk("c2_err_sum", es_c, m_sum[1]);
      chk("c2_max_err", mx_c, m_max[1]);
    end
  endtask

  // One vector through a WIDTH=8 instance (sel 0: main, sel 1: narrow counters).
  task automatic run8(input int sel, input int a, input int b, input int p);
    int k;
    longint g, e;
    k = 0;
    while (((sel == 0) ? rdy_m : rdy_c) !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    chk("ready_before", (sel == 0) ? rdy_m : rdy_c, 1);
    va = 8'(a); vb = 8'(b); vp = 16'(p);
    if (sel == 0) iv_m = 1'b1; else iv_c = 1'b1;
    @(negedge clk);
    iv_m = 1'b0; iv_c = 1'b0;
    va = 8'($urandom); vb = 8'($urandom); vp = 16'($urandom);
    chk("ready_low", (sel == 0) ? rdy_m : rdy_c, 0);
    k = 1;
    while (((sel == 0) ? rv_m : rv_c) !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    chk("latency", k, 9);
    g = longint'(a) * longint'(b);
    e = (p >= g) ? p - g : g - p;
    chk("res_match", (sel == 0) ? rm_m : rm_c, (e == 0) ? 1 : 0);
    chk("res_err", (sel == 0) ? re_m : re_c, e);
    @(negedge clk);
    model_update(sel, a, b, p);
    chk("ready_back", (sel == 0) ? rdy_m : rdy_c, 1);
    chk("res_valid_pulse", (sel == 0) ? rv_m : rv_c, 0);
    check_stats(sel);
  endtask

  task automatic run2(input int a, input int b, input int p);
    int k;
    k = 0;
    while (rdy_2 !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    wa = 2'(a); wb = 2'(b); wp = 4'(p); iv_2 = 1'b1;
    @(negedge clk);
    iv_2 = 1'b0; wa = 2'($urandom); wb = 2'($urandom); wp = 4'($urandom);
    k = 1;
    while (rv_2 !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    chk("w2_latency", k, 3);
    chk("w2_res_match", rm_2, (a * b == p) ? 1 : 0);
    @(negedge clk);
    m2_vec++;
    chk("w2_vec_count", vc_2, m2_vec);
    chk("w2_mismatch_count", mc_2, 0);
  endtask

  initial begin
    int acc_n, pulse_n, first_acc, second_acc, a, b, p, mode;
    cmax[0] = 65535;          cmax[1] = 3;
    smax[0] = 64'hFFFF_FFFF;  smax[1] = 64'h3_FFFF;
    model_reset();
    rst_n = 1'b0; clear = 1'b0;
    iv_m = 1'b0; iv_c = 1'b0; iv_2 = 1'b0;
    va = '0; vb = '0; vp = '0; wa = '0; wb = '0; wp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", rdy_m, 1);
    chk("rst_res_valid", rv_m, 0);
    chk("rst_res_match", rm_m, 0);
    chk("rst_res_err", re_m, 0);
    check_stats(0);

    run8(0, 15, 15, 225);
    run8(0, 15, 15, 200);
    run8(0, 3, 3, 10);
    run8(0, 255, 255, 65025);
    run8(0, 0, 200, 0);

    // in_valid held high: only one acceptance per 10 cycles.
    va = 8'd7; vb = 8'd9; vp = 16'd63; iv_m = 1'b1;
    acc_n = 0; pulse_n = 0; first_acc = -1; second_acc = -1;
    for (int i = 0; i < 30; i++) begin
      if (rdy_m) begin
        if (acc_n == 0) first_acc = i;
        if (acc_n == 1) second_acc = i;
        acc_n++;
      end
      if (rv_m) pulse_n++;
      @(negedge clk);
    end
    iv_m = 1'b0;
    chk("b2b_accepts", acc_n, 3);
    chk("b2b_pulses", pulse_n, 3);
    chk("b2b_spacing", second_acc - first_acc, 10);
    for (int i = 0; i < 3; i++) model_update(0, 7, 9, 63);
    check_stats(0);

    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 2));
      if (mode == 0) p = a * b;
      else if (mode == 1) p = a * b + int'($urandom_range(1, 500));
      else p = int'($urandom_range(0, 65535));
      if (p > 65535) p = 65535;
      run8(0, a, b, p);
    end

    // clear four cycles into MUL aborts the vector and zeroes statistics.
    va = 8'd15; vb = 8'd15; vp = 16'd200; iv_m = 1'b1;
    @(negedge clk);
    iv_m = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    chk("clear_in_ready", rdy_m, 1);
    check_stats(0);
    pulse_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (rv_m) pulse_n++;
      @(negedge clk);
    end
    chk("clear_no_pulse", pulse_n, 0);
    check_stats(0);

    run8(0, 12, 11, 130);
    run8(0, 200, 100, 20000);

    run2(2, 2, 4);
    run2(3, 3, 9);
    run2(3, 1, 3);

    for (int i = 0; i < 5; i++) begin
      a = int'($urandom_range(0, 200));
      b = int'($urandom_range(0, 200));
      run8(1, a, b, a * b + 1);
    end
    chk("c2_vec_sat", vc_c, 3);
    chk("c2_mis_sat", mc_c, 3);
    chk("c2_err_sum", es_c, 5);

    // Asynchronous reset in the middle of MUL.
    va = 8'd9; vb = 8'd9; vp = 16'd80; iv_m = 1'b1;
    @(negedge clk);
    iv_m = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", rdy_m, 1);
    chk("arst_res_valid", rv_m, 0);
    chk("arst_vec_count", vc_m, 0);
    chk("arst_err_sum", es_m, 0);
    chk("arst_fail_valid", fv_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    pulse_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (rv_m) pulse_n++;
      @(negedge clk);
    end
    chk("arst_no_pulse", pulse_n, 0);
    check_stats(0);
    run8(0, 9, 9, 81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
